// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Single-stage instruction fetch unit with a valid/ready output stage.
// A START pulse leaves IDLE and begins fetching sequential words from
// BOOT_ADDR out of an asynchronous (combinational-read) instruction memory.
// Each fetched word is registered into the output stage together with its
// byte PC and is held there while decode back-pressures. Aligned redirects
// flush the output stage and restart fetching at the target. A misaligned
// redirect parks the unit in ERROR with a sticky FETCH_ERR until RESET.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   START                 one-cycle pulse: IDLE -> FETCH at BOOT_ADDR
//   READ_EN, INS_ADDRESS  instruction memory read enable / word address
//   INSTRUCTION           same-cycle read data from instruction memory
//   IF_VALID, IF_READY    output stage handshake towards decode
//   IF_INSTR, IF_PC       held instruction and its byte address
//   REDIRECT_EN/_PC       branch/jump redirect request and byte target
//   FETCH_ERR             sticky misaligned-redirect error
//   FETCH_COUNT           completed decode transfers
//
// Optional feature: define FETCH_COUNT_EN to build the transfer counter;
// otherwise FETCH_COUNT is tied to zero.
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int unsigned TAM_POSICIONES = 1024,
  parameter int unsigned TAM_PALABRA    = 32,
  parameter int unsigned BOOT_ADDR      = 0,
  localparam int unsigned AW = $clog2(TAM_POSICIONES),
  localparam int unsigned PW = AW + 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  output logic                   READ_EN,
  output logic [AW-1:0]          INS_ADDRESS,
  input  logic [TAM_PALABRA-1:0] INSTRUCTION,
  output logic                   IF_VALID,
  input  logic                   IF_READY,
  output logic [TAM_PALABRA-1:0] IF_INSTR,
  output logic [PW-1:0]          IF_PC,
  input  logic                   REDIRECT_EN,
  input  logic [PW-1:0]          REDIRECT_PC,
  output logic                   FETCH_ERR,
  output logic [31:0]            FETCH_COUNT
);

  localparam logic [PW-1:0] BOOT_PC = PW'(BOOT_ADDR);
  localparam logic [PW-1:0] PC_STEP = PW'(3'd4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [PW-1:0]          pc_r;
  logic                   if_valid_r;
  logic [TAM_PALABRA-1:0] if_instr_r;
  logic [PW-1:0]          if_pc_r;
  logic                   fetch_err_r;

  logic                   start_s;     // IDLE accepting START
  logic                   load_s;      // output stage captures INSTRUCTION
  logic                   redirect_s;  // aligned redirect accepted
  logic                   misalign_s;  // misaligned redirect -> ERROR

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_s    = state_r;
    start_s    = 1'b0;
    load_s     = 1'b0;
    redirect_s = 1'b0;
    misalign_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          start_s = 1'b1;
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        // A redirect always wins over a load: the word at the old PC is
        // stale once the stream has been redirected.
        if (REDIRECT_EN) begin
          if (REDIRECT_PC[1:0] != 2'b00) begin
            misalign_s = 1'b1;
            state_s    = ERROR;
          end else begin
            redirect_s = 1'b1;
            state_s    = FETCH;
          end
        end else if (!if_valid_r || IF_READY) begin
          load_s  = 1'b1;
          state_s = FETCH;
        end else begin
          state_s = FETCH;
        end
      end
      ERROR: begin
        state_s = ERROR;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // PC, output stage and sticky error flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_r        <= BOOT_PC;
      if_valid_r  <= 1'b0;
      if_instr_r  <= '0;
      if_pc_r     <= '0;
      fetch_err_r <= 1'b0;
    end else begin
      if (start_s) begin
        pc_r <= BOOT_PC;
      end else if (redirect_s) begin
        pc_r <= REDIRECT_PC;
      end else if (load_s) begin
        // Natural PW-bit overflow gives the wrap back to byte address 0.
        pc_r <= pc_r + PC_STEP;
      end else begin
        pc_r <= pc_r;
      end

      if (load_s) begin
        if_instr_r <= INSTRUCTION;
        if_pc_r    <= pc_r;
        if_valid_r <= 1'b1;
      end else if (redirect_s || misalign_s) begin
        // A transfer coinciding with the redirect has already completed
        // this edge; only the valid bit is dropped, data is left as is.
        if_valid_r <= 1'b0;
      end else begin
        if_valid_r <= if_valid_r;
      end

      if (misalign_s) begin
        fetch_err_r <= 1'b1;
      end else begin
        fetch_err_r <= fetch_err_r;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_r;
  logic        xfer_s;

  assign xfer_s = if_valid_r & IF_READY;

  // Completed decode transfers, wrapping modulo 2^32
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_count_r <= 32'd0;
    end else if (xfer_s) begin
      fetch_count_r <= fetch_count_r + 32'd1;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  assign FETCH_COUNT = fetch_count_r;
`else
  assign FETCH_COUNT = 32'd0;
`endif

  // Memory address tracks the PC even when no read is requested.
  assign INS_ADDRESS = pc_r[PW-1:2];
  assign READ_EN     = load_s;
  assign IF_VALID    = if_valid_r;
  assign IF_INSTR    = if_instr_r;
  assign IF_PC       = if_pc_r;
  assign FETCH_ERR   = fetch_err_r;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameters SHALL be: TAM_POSICIONES, 1024, number of instruction-memory words; TAM_PALABRA, 32, instruction width in bits; BOOT_ADDR, 0, byte address of the first fetch.
REQ-002 Derived widths SHALL be AW = $clog2(TAM_POSICIONES) for the word address and PW = AW+2 for the byte PC.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 START  in  1  single-cycle pulse that begins fetching from BOOT_ADDR.
REQ-006 READ_EN  out  1  read enable to the asynchronous instruction memory.
REQ-007 INS_ADDRESS  out  AW  word address to the instruction memory, equal to PC[PW-1:2].
REQ-008 INSTRUCTION  in  TAM_PALABRA  combinational read data returned by the instruction memory in the same cycle.
REQ-009 IF_VALID  out  1  output stage holds a valid instruction.
REQ-010 IF_READY  in  1  decode stage accepts the output stage; a transfer occurs when IF_VALID and IF_READY are both 1.
REQ-011 IF_INSTR  out  TAM_PALABRA  instruction held in the output stage.
REQ-012 IF_PC  out  PW  byte address of IF_INSTR.
REQ-013 REDIRECT_EN  in  1  branch/jump redirect request.
REQ-014 REDIRECT_PC  in  PW  byte target of the redirect.
REQ-015 FETCH_ERR  out  1  sticky misaligned-redirect error flag.
REQ-016 FETCH_COUNT  out  32  count of completed decode transfers.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, FETCH, ERROR.
REQ-018 IDLE -> FETCH SHALL occur on START=1, with PC loaded to BOOT_ADDR; START SHALL be ignored in FETCH and ERROR.
REQ-019 In FETCH, READ_EN SHALL be 1 exactly in the cycles where the output stage loads: IF_VALID=0 or IF_READY=1, and REDIRECT_EN=0.
REQ-020 On a load, IF_INSTR<=INSTRUCTION, IF_PC<=PC, IF_VALID<=1 and PC<=PC+4, so the output stage registers data one cycle after the address is presented.
REQ-021 When IF_VALID=1 and IF_READY=0, the output stage, PC and INS_ADDRESS SHALL hold stable.
REQ-022 PC+4 SHALL wrap modulo 2^PW, so after the last word the fetch continues at byte address 0.
REQ-023 A redirect in FETCH with REDIRECT_PC[1:0]=0 SHALL load PC<=REDIRECT_PC, clear IF_VALID next cycle, and resume loading in the following cycle.
REQ-024 A redirect with REDIRECT_PC[1:0]!=0 SHALL move the FSM to ERROR, clear IF_VALID, and set FETCH_ERR.
REQ-025 REDIRECT_EN SHALL be ignored in IDLE and ERROR.
REQ-026 Redirect coincident with a transfer: the transfer SHALL complete and be counted, and the redirect SHALL still flush the output stage.
REQ-027 In ERROR, READ_EN, IF_VALID SHALL be 0 and FETCH_ERR SHALL be 1 until RESET.
REQ-028 With READ_EN=0, INS_ADDRESS SHALL still equal PC[PW-1:2].

Reset
REQ-029 RESET=1 at any clock edge SHALL force the state to IDLE, PC to BOOT_ADDR, IF_VALID, READ_EN and FETCH_ERR to 0, IF_INSTR and IF_PC to 0, and FETCH_COUNT to 0.
REQ-030 RESET SHALL take priority over START, REDIRECT_EN and any in-flight transfer; a reset mid-stall SHALL discard the held instruction.

Configuration
REQ-031 With macro FETCH_COUNT_EN defined, FETCH_COUNT SHALL increment by 1 on each transfer and wrap modulo 2^32.
REQ-032 Without FETCH_COUNT_EN, FETCH_COUNT SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-033 Boot: RESET, then START pulse with memory word0=0x00000013 and word1=0x00100093, IF_READY=1 -> IF_VALID rises 2 cycles after START, with IF_PC=0x0/IF_INSTR=0x00000013, then 0x4/0x00100093.
REQ-034 Stall: IF_READY=0 for 5 cycles while IF_VALID=1 -> IF_INSTR, IF_PC and INS_ADDRESS are unchanged, and READ_EN=0 throughout.
REQ-035 Redirect: REDIRECT_EN=1 with REDIRECT_PC=0x40 during a transfer -> FETCH_COUNT increments once, IF_VALID=0 for one cycle, and the next IF_PC is 0x40.
REQ-036 Misaligned: REDIRECT_PC=0x42 -> FETCH_ERR=1 and IF_VALID=0 permanently, and START is ignored until RESET.
REQ-037 Wrap: redirect to 0xFFC (TAM_POSICIONES=1024) -> IF_PC sequence is 0xFFC then 0x000.
REQ-038 Reset mid-stall: RESET during IF_VALID=1/IF_READY=0 -> the next cycle shows IF_VALID=0, FETCH_COUNT=0 and state IDLE.
